// File: rtl/axis_rr_arbiter_if.sv
// Stream bundle around the round-robin arbiter: NUM_PORTS packed slave inputs and one tagged master output.
// The master modport is the arbiter's view; the slave modport is the surrounding producers/consumer.
interface axis_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 8
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]            s_axis_tvalid;
  logic [NUM_PORTS-1:0]            s_axis_tlast;
  logic [NUM_PORTS-1:0]            s_axis_tready;
  logic [DATA_WIDTH-1:0]           m_axis_tdata;
  logic                            m_axis_tvalid;
  logic                            m_axis_tlast;
  logic [ID_WIDTH-1:0]             m_axis_tid;
  logic                            m_axis_tready;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    input  m_axis_tready
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid,
    output m_axis_tready
  );
endinterface

// File: rtl/axis_rr_arbiter.sv
// Packet-atomic round-robin arbiter merging NUM_PORTS AXI4-Stream inputs onto one output tagged with tid.
// Optional ARB_STATS_EN adds per-port completed-packet counters (pkt_count) and an arb_busy flag.
module axis_rr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int ID_WIDTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  axis_rr_arbiter_if.master       axis
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_PORTS*16-1:0] pkt_count,
  output logic                    arb_busy
`endif
);

  localparam int GW = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_reg, state_next;
  logic [GW-1:0]   grant_reg, grant_next;
  logic [GW-1:0]   last_grant_reg, last_grant_next;
  logic [GW-1:0]   sel;
  logic            sel_found;
  logic [DATA_WIDTH-1:0] port_data [NUM_PORTS];

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
      assign port_data[gi] = axis.s_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // First requester strictly after last_grant, wrapping, so the last winner has lowest priority.
  always_comb begin
    int      idx;
    logic [GW-1:0] cand;
    sel       = last_grant_reg;
    sel_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = int'(last_grant_reg) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      cand = GW'(idx);
      if (!sel_found && axis.s_axis_tvalid[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_PORTS - 1);
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    grant_next         = grant_reg;
    last_grant_next    = last_grant_reg;
    axis.m_axis_tdata  = '0;
    axis.m_axis_tvalid = 1'b0;
    axis.m_axis_tlast  = 1'b0;
    axis.m_axis_tid    = '0;
    axis.s_axis_tready = '0;
    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          grant_next      = sel;
          last_grant_next = sel;
          state_next      = XFER;
        end
      end
      XFER: begin
        // Grant is held until the tlast beat is accepted, even across source bubbles.
        axis.m_axis_tdata         = port_data[grant_reg];
        axis.m_axis_tvalid        = axis.s_axis_tvalid[grant_reg];
        axis.m_axis_tlast         = axis.s_axis_tlast[grant_reg];
        axis.m_axis_tid           = ID_WIDTH'(grant_reg);
        axis.s_axis_tready[grant_reg] = axis.m_axis_tready;
        if (axis.s_axis_tvalid[grant_reg] && axis.m_axis_tready && axis.s_axis_tlast[grant_reg]) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef ARB_STATS_EN
  logic pkt_done;

  assign pkt_done = (state_reg == XFER) && axis.m_axis_tvalid && axis.m_axis_tready && axis.m_axis_tlast;
  assign arb_busy = (state_reg == XFER);

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_stats
      logic [15:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (pkt_done && (grant_reg == GW'(gi))) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign pkt_count[gi*16 +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: directed scenarios plus a randomized run against a packet-level model.
module tb_axis_rr_arbiter;
  localparam int NP = 4;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  axis_rr_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(8), .ID_WIDTH(8)) bus ();

`ifdef ARB_STATS_EN
  logic [NP*16-1:0] pkt_count;
  logic             arb_busy;
`endif

  axis_rr_arbiter #(.DATA_WIDTH(8), .NUM_PORTS(NP), .ID_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .axis      (bus)
`ifdef ARB_STATS_EN
    ,
    .pkt_count (pkt_count),
    .arb_busy  (arb_busy)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.s_axis_tdata  = '0;
    bus.s_axis_tvalid = '0;
    bus.s_axis_tlast  = '0;
  endtask

  task automatic set_port(input int p, input logic [7:0] d, input logic l, input logic v);
    bus.s_axis_tdata[p*8 +: 8] = d;
    bus.s_axis_tlast[p]        = l;
    bus.s_axis_tvalid[p]       = v;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    bus.m_axis_tready = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.m_axis_tready = 1'b1;
    for (int p = 0; p < NP; p++) set_port(p, 8'(8'h10 + p), 1'b1, 1'b1);
    next_cycle();
    next_cycle();
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b expected 0", bus.m_axis_tvalid); end
    checks++; if (bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %0b expected 0", bus.m_axis_tlast); end
    checks++; if (bus.m_axis_tdata !== 8'h00) begin errors++; $display("FAIL reset_tdata: got %0h expected 0", bus.m_axis_tdata); end
    checks++; if (bus.m_axis_tid !== 8'h00) begin errors++; $display("FAIL reset_tid: got %0h expected 0", bus.m_axis_tid); end
    checks++; if (bus.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL reset_s_tready: got %b expected 0000", bus.s_axis_tready); end
    $display("test_reset done");
    clear_inputs();
    rst = 1'b0;
  endtask

  task automatic test_single_packet();
    logic [7:0] d;
    do_reset();
    set_port(2, 8'hA1, 1'b0, 1'b1);
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_first_cycle_idle: got tvalid %0b expected 0", bus.m_axis_tvalid); end
    for (int b = 0; b < 3; b++) begin
      next_cycle();
      d = 8'(8'hA1 + b);
      set_port(2, d, (b == 2), 1'b1);
      #1;
      $display("single beat %0d: tid=%0d data=%02h last=%0b", b, bus.m_axis_tid, bus.m_axis_tdata, bus.m_axis_tlast);
      checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== d) begin errors++; $display("FAIL single_data: got v=%0b d=%02h expected v=1 d=%02h", bus.m_axis_tvalid, bus.m_axis_tdata, d); end
      checks++; if (bus.m_axis_tid !== 8'd2) begin errors++; $display("FAIL single_tid: got %0d expected 2", bus.m_axis_tid); end
      checks++; if (bus.m_axis_tlast !== (b == 2)) begin errors++; $display("FAIL single_tlast: got %0b expected %0b", bus.m_axis_tlast, (b == 2)); end
      checks++; if (bus.s_axis_tready !== 4'b0100) begin errors++; $display("FAIL single_s_tready: got %b expected 0100", bus.s_axis_tready); end
    end
    next_cycle();
    clear_inputs();
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_return_idle: got tvalid %0b expected 0", bus.m_axis_tvalid); end
  endtask

  task automatic test_fairness();
    int bc [NP];
    int nbeats = 0;
    int exp_tid;
    logic [7:0] exp_d;
    logic hs;
    do_reset();
    for (int p = 0; p < NP; p++) bc[p] = 0;
    for (int c = 0; c < 18; c++) begin
      for (int p = 0; p < NP; p++) set_port(p, 8'(p*16 + bc[p]), (bc[p] == 1), 1'b1);
      #1;
      hs = bus.m_axis_tvalid & bus.m_axis_tready;
      checks++; if (hs !== ((c % 3) != 0)) begin errors++; $display("FAIL fair_beat_slot c=%0d: got %0b expected %0b", c, hs, ((c % 3) != 0)); end
      if (hs) begin
        exp_tid = (nbeats / 2) % NP;
        exp_d   = 8'(exp_tid*16 + (nbeats % 2));
        $display("fair beat %0d: tid=%0d data=%02h", nbeats, bus.m_axis_tid, bus.m_axis_tdata);
        checks++; if (bus.m_axis_tid !== 8'(exp_tid)) begin errors++; $display("FAIL fair_tid beat=%0d: got %0d expected %0d", nbeats, bus.m_axis_tid, exp_tid); end
        checks++; if (bus.m_axis_tdata !== exp_d) begin errors++; $display("FAIL fair_data beat=%0d: got %02h expected %02h", nbeats, bus.m_axis_tdata, exp_d); end
        nbeats++;
      end
      for (int p = 0; p < NP; p++) if (bus.s_axis_tready[p] && bus.s_axis_tvalid[p]) bc[p] ^= 1;
      next_cycle();
    end
    checks++; if (nbeats != 12) begin errors++; $display("FAIL fair_beat_count: got %0d expected 12", nbeats); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int nrx = 0;
    logic [7:0] got [3];
    do_reset();
    for (int c = 0; c < 10; c++) begin
      bus.m_axis_tready = !(c >= 2 && c <= 6);
      if (idx < 3) set_port(1, 8'(8'hB0 + idx), (idx == 2), 1'b1);
      else set_port(1, 8'h00, 1'b0, 1'b0);
      #1;
      if (c >= 2 && c <= 6) begin
        checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 8'hB1) begin errors++; $display("FAIL bp_stable c=%0d: got v=%0b d=%02h expected v=1 d=b1", c, bus.m_axis_tvalid, bus.m_axis_tdata); end
        checks++; if (bus.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL bp_s_tready c=%0d: got %b expected 0000", c, bus.s_axis_tready); end
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        $display("bp beat: tid=%0d data=%02h last=%0b", bus.m_axis_tid, bus.m_axis_tdata, bus.m_axis_tlast);
        checks++; if (bus.m_axis_tid !== 8'd1) begin errors++; $display("FAIL bp_tid: got %0d expected 1", bus.m_axis_tid); end
        if (nrx < 3) got[nrx] = bus.m_axis_tdata;
        nrx++;
      end
      if (bus.s_axis_tready[1] && bus.s_axis_tvalid[1]) idx++;
      next_cycle();
    end
    checks++; if (nrx != 3) begin errors++; $display("FAIL bp_count: got %0d expected 3", nrx); end
    for (int i = 0; i < 3 && i < nrx; i++) begin
      checks++; if (got[i] !== 8'(8'hB0 + i)) begin errors++; $display("FAIL bp_order i=%0d: got %02h expected %02h", i, got[i], 8'(8'hB0 + i)); end
    end
    bus.m_axis_tready = 1'b1;
    clear_inputs();
  endtask

  task automatic test_source_stall();
    logic p3_done = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      if (c <= 1) set_port(0, 8'h01, 1'b0, 1'b1);
      else if (c == 6) set_port(0, 8'h02, 1'b1, 1'b1);
      else set_port(0, 8'h00, 1'b0, 1'b0);
      set_port(3, 8'h33, 1'b1, !p3_done);
      #1;
      if (c == 1 || c == 6) begin
        checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tid !== 8'd0 || bus.m_axis_tdata !== (c == 1 ? 8'h01 : 8'h02)) begin errors++; $display("FAIL stall_port0_beat c=%0d: got v=%0b tid=%0d d=%02h", c, bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tdata); end
      end
      if (c >= 2 && c <= 5) begin
        checks++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tid !== 8'd0) begin errors++; $display("FAIL stall_hold c=%0d: got v=%0b tid=%0d expected v=0 tid=0", c, bus.m_axis_tvalid, bus.m_axis_tid); end
        checks++; if (bus.s_axis_tready !== 4'b0001) begin errors++; $display("FAIL stall_s_tready c=%0d: got %b expected 0001", c, bus.s_axis_tready); end
      end
      if (c == 7 || c == 9) begin
        checks++; if (bus.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL stall_idle c=%0d: got tvalid %0b expected 0", c, bus.m_axis_tvalid); end
      end
      if (c == 8) begin
        checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tid !== 8'd3 || bus.m_axis_tdata !== 8'h33) begin errors++; $display("FAIL stall_port3_grant: got v=%0b tid=%0d d=%02h expected v=1 tid=3 d=33", bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tdata); end
        checks++; if (bus.s_axis_tready !== 4'b1000) begin errors++; $display("FAIL stall_port3_ready: got %b expected 1000", bus.s_axis_tready); end
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) $display("stall beat c=%0d: tid=%0d data=%02h", c, bus.m_axis_tid, bus.m_axis_tdata);
      if (bus.s_axis_tready[3] && bus.s_axis_tvalid[3]) p3_done = 1'b1;
      next_cycle();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    set_port(1, 8'hC0, 1'b0, 1'b1);
    #1;
    next_cycle();
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tid !== 8'd1) begin errors++; $display("FAIL rstmid_first_beat: got v=%0b tid=%0d expected v=1 tid=1", bus.m_axis_tvalid, bus.m_axis_tid); end
    next_cycle();
    set_port(1, 8'hC1, 1'b0, 1'b1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    set_port(0, 8'h0D, 1'b1, 1'b1);
    set_port(1, 8'hC2, 1'b0, 1'b1);
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rstmid_ctrl: got v=%0b l=%0b expected 0 0", bus.m_axis_tvalid, bus.m_axis_tlast); end
    checks++; if (bus.m_axis_tdata !== 8'h00 || bus.m_axis_tid !== 8'h00) begin errors++; $display("FAIL rstmid_data: got d=%02h tid=%0d expected 0 0", bus.m_axis_tdata, bus.m_axis_tid); end
    checks++; if (bus.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL rstmid_s_tready: got %b expected 0000", bus.s_axis_tready); end
    next_cycle();
    #1;
    checks++; if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tid !== 8'd0 || bus.m_axis_tdata !== 8'h0D) begin errors++; $display("FAIL rstmid_port0_first: got v=%0b tid=%0d d=%02h expected v=1 tid=0 d=0d", bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tdata); end
    checks++; if (bus.s_axis_tready !== 4'b0001) begin errors++; $display("FAIL rstmid_ready: got %b expected 0001", bus.s_axis_tready); end
    $display("rstmid beat: tid=%0d data=%02h", bus.m_axis_tid, bus.m_axis_tdata);
    next_cycle();
    clear_inputs();
  endtask

`ifdef ARB_STATS_EN
  task automatic test_stats();
    int sent = 0;
    logic exp_busy;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      if (sent < 5) set_port(2, 8'(8'h50 + sent), 1'b1, 1'b1);
      else set_port(2, 8'h00, 1'b0, 1'b0);
      #1;
      exp_busy = ((c % 2) == 1) && (c <= 9);
      checks++; if (arb_busy !== exp_busy) begin errors++; $display("FAIL stats_busy c=%0d: got %0b expected %0b", c, arb_busy, exp_busy); end
      if (bus.s_axis_tready[2] && bus.s_axis_tvalid[2]) sent++;
      next_cycle();
    end
    for (int p = 0; p < NP; p++) begin
      checks++; if (pkt_count[p*16 +: 16] !== ((p == 2) ? 16'd5 : 16'd0)) begin errors++; $display("FAIL stats_count p=%0d: got %0d expected %0d", p, pkt_count[p*16 +: 16], (p == 2) ? 5 : 0); end
    end
    $display("stats: port2 count=%0d", pkt_count[2*16 +: 16]);
    clear_inputs();
  endtask
`endif

  // Packet-level model: per-port beat lists, owner of the output, round-robin pick from the last owner.
  task automatic test_random();
    logic [8:0] mem [NP][64];
    int   head [NP];
    int   tail [NP];
    logic offering [NP];
    int   total = 0;
    int   beats_out = 0;
    int   owner = -1;
    int   last = NP - 1;
    int   cyc = 0;
    int   npk, len, idx, pick;
    logic pending;
    logic [3:0] exp_ready;
    do_reset();
    for (int p = 0; p < NP; p++) begin
      head[p] = 0;
      tail[p] = 0;
      offering[p] = 1'b0;
      npk = $urandom_range(1, 4);
      for (int k = 0; k < npk; k++) begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          mem[p][tail[p]] = {(b == len - 1), 8'($urandom)};
          tail[p]++;
          total++;
        end
      end
    end
    pending = 1'b1;
    while (pending && cyc < 4000) begin
      for (int p = 0; p < NP; p++) begin
        if (!offering[p] && head[p] < tail[p] && $urandom_range(0, 3) != 0) offering[p] = 1'b1;
        if (head[p] < tail[p]) set_port(p, mem[p][head[p]][7:0], mem[p][head[p]][8], offering[p]);
        else set_port(p, 8'h00, 1'b0, 1'b0);
      end
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      #1;
      if (owner < 0) begin
        checks++; if (bus.m_axis_tvalid !== 1'b0 || bus.s_axis_tready !== 4'b0000) begin errors++; $display("FAIL rnd_idle cyc=%0d: got v=%0b rdy=%b expected 0 0000", cyc, bus.m_axis_tvalid, bus.s_axis_tready); end
        pick = -1;
        for (int k = 1; k <= NP; k++) begin
          idx = (last + k) % NP;
          if (pick < 0 && offering[idx]) pick = idx;
        end
        owner = pick;
      end else begin
        exp_ready = bus.m_axis_tready ? 4'(1 << owner) : 4'b0000;
        checks++; if (bus.m_axis_tid !== 8'(owner) || bus.m_axis_tvalid !== offering[owner] || bus.s_axis_tready !== exp_ready) begin errors++; $display("FAIL rnd_grant cyc=%0d: got tid=%0d v=%0b rdy=%b expected tid=%0d v=%0b rdy=%b", cyc, bus.m_axis_tid, bus.m_axis_tvalid, bus.s_axis_tready, owner, offering[owner], exp_ready); end
        if (offering[owner]) begin
          checks++; if ({bus.m_axis_tlast, bus.m_axis_tdata} !== mem[owner][head[owner]]) begin errors++; $display("FAIL rnd_beat cyc=%0d: got %03h expected %03h", cyc, {bus.m_axis_tlast, bus.m_axis_tdata}, mem[owner][head[owner]]); end
          if (bus.m_axis_tready) begin
            $display("rnd beat %0d: tid=%0d data=%02h last=%0b", beats_out, owner, mem[owner][head[owner]][7:0], mem[owner][head[owner]][8]);
            beats_out++;
            offering[owner] = 1'b0;
            if (mem[owner][head[owner]][8]) begin
              head[owner]++;
              last = owner;
              owner = -1;
            end else begin
              head[owner]++;
            end
          end
        end
      end
      pending = (owner >= 0);
      for (int p = 0; p < NP; p++) if (head[p] < tail[p]) pending = 1'b1;
      next_cycle();
      cyc++;
    end
    checks++; if (beats_out != total) begin errors++; $display("FAIL rnd_drain: got %0d beats expected %0d within %0d cycles", beats_out, total, cyc); end
    bus.m_axis_tready = 1'b1;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.m_axis_tready = 1'b0;
    test_reset();
    test_single_packet();
    test_fairness();
    test_backpressure();
    test_source_stall();
    test_reset_mid_packet();
`ifdef ARB_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
